face_result_packer: RTL and testbench

//  Collects face rectangles produced by detect_face_wrapper during one frame, then, on frame end,

---
 rtl/vj_pkg.sv | 41 ++++
 rtl/face_store.sv | 25 ++
 rtl/face_result_packer.sv | 144 ++++++++++++++
 tb/tb_face_result_packer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vj_pkg.sv
// Shared types for the Viola-Jones result path: face record, packer states and
// the byte helpers used when serialising a frame packet.
package vj_pkg;

    localparam int HDR_OVF_BIT = 7;

    typedef struct packed {
        logic [7:0] x1;
        logic [7:0] y1;
        logic [7:0] x2;
        logic [7:0] y2;
    } face_t;

    typedef enum logic [1:0] {
        COLLECT,
        HDR,
        FACE,
        DONE
    } pkt_state_e;

    function automatic logic [7:0] make_header(input logic ovf, input logic [6:0] cnt);
        logic [7:0] h;
        h = {1'b0, cnt};
        h[HDR_OVF_BIT] = ovf;
        return h;
    endfunction

    // Byte order on the wire is x1, y1, x2, y2.
    function automatic logic [7:0] face_byte(input face_t f, input logic [1:0] sel);
        logic [7:0] b;
        b = f.x1;
        unique case (sel)
            2'd0: b = f.x1;
            2'd1: b = f.y1;
            2'd2: b = f.x2;
            2'd3: b = f.y2;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/face_store.sv
// Per-frame face buffer: one synchronous write port, one asynchronous read port.
// No reset so it maps onto distributed RAM; contents are only read below count.
module face_store #(
    parameter int unsigned DEPTH = 30,
    parameter int unsigned AW    = 5
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/face_result_packer.sv
// Collects face rectangles for one frame, then streams a header byte plus
// x1,y1,x2,y2 per stored face into the UART transmitter handshake.
module face_result_packer
    import vj_pkg::*;
#(
    parameter int unsigned MAX_FACES = 30,
    parameter int unsigned COORD_W   = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               face_vld,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic               frame_done,
    input  logic               uart_data_sent,
    output logic               send_uart_data,
    output logic [7:0]         uart_data_tx,
    output logic               busy,
    output logic               frame_overrun
);

    localparam int unsigned AW = (MAX_FACES > 1) ? $clog2(MAX_FACES) : 1;
    localparam logic [6:0]  MaxCount = 7'(MAX_FACES);

    pkt_state_e    state_q, state_d;
    logic [6:0]    count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic [1:0]    byte_sel_q, byte_sel_d;
    logic          send_q, send_d;
    logic [7:0]    tx_q, tx_d;
    logic          overrun_q, overrun_d;

    logic          wr_en;
    logic [31:0]   rd_data;

    face_store #(
        .DEPTH (MAX_FACES),
        .AW    (AW)
    ) u_store (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_idx  (count_q[AW-1:0]),
        .wr_data ({x1, y1, x2, y2}),
        .rd_idx  (rd_idx_q),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        rd_idx_d   = rd_idx_q;
        byte_sel_d = byte_sel_q;
        send_d     = send_q;
        tx_d       = tx_q;
        overrun_d  = overrun_q;
        wr_en      = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (face_vld) begin
                    if (count_q < MaxCount) begin
                        wr_en   = 1'b1;
                        count_d = count_q + 7'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                // Header uses next-state count/ovf so a same-cycle face is counted.
                if (frame_done) begin
                    state_d = HDR;
                    send_d  = 1'b1;
                    tx_d    = make_header(ovf_d, count_d);
                end
            end
            HDR: begin
                if (send_q && uart_data_sent) begin
                    send_d     = 1'b0;
                    rd_idx_d   = '0;
                    byte_sel_d = '0;
                    state_d    = (count_q == 7'd0) ? DONE : FACE;
                end
            end
            FACE: begin
                // One idle cycle after each accepted byte, then the next byte is presented.
                if (!send_q) begin
                    send_d = 1'b1;
                    tx_d   = face_byte(rd_data, byte_sel_q);
                end else if (uart_data_sent) begin
                    send_d     = 1'b0;
                    byte_sel_d = byte_sel_q + 2'd1;
                    if (byte_sel_q == 2'd3) begin
                        rd_idx_d = rd_idx_q + AW'(1);
                        if (7'(rd_idx_q) + 7'd1 == count_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                send_d  = 1'b0;
                count_d = '0;
                ovf_d   = 1'b0;
                state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase

        if (state_q != COLLECT && frame_done) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= COLLECT;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_idx_q   <= '0;
            byte_sel_q <= '0;
            send_q     <= 1'b0;
            tx_q       <= 8'h00;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rd_idx_q   <= rd_idx_d;
            byte_sel_q <= byte_sel_d;
            send_q     <= send_d;
            tx_q       <= tx_d;
            overrun_q  <= overrun_d;
        end
    end

    assign send_uart_data = send_q;
    assign uart_data_tx   = tx_q;
    assign busy           = (state_q != COLLECT);
    assign frame_overrun  = overrun_q;

endmodule

// File: tb/tb_face_result_packer.sv
// Bench for face_result_packer: table-driven frames, directed corner cases and
// random frames, all checked against a queue-based packet model.
module tb_face_result_packer;

    localparam int MAX_FACES = 30;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       face_vld = 1'b0;
    logic       frame_done = 1'b0;
    logic       uart_data_sent = 1'b0;
    logic [7:0] x1 = 8'h00, y1 = 8'h00, x2 = 8'h00, y2 = 8'h00;
    logic       send_uart_data;
    logic [7:0] uart_data_tx;
    logic       busy;
    logic       frame_overrun;

    face_result_packer #(
        .MAX_FACES (MAX_FACES),
        .COORD_W   (8)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .face_vld       (face_vld),
        .x1             (x1),
        .y1             (y1),
        .x2             (x2),
        .y2             (y2),
        .frame_done     (frame_done),
        .uart_data_sent (uart_data_sent),
        .send_uart_data (send_uart_data),
        .uart_data_tx   (uart_data_tx),
        .busy           (busy),
        .frame_overrun  (frame_overrun)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail = 0;
    int          lat_max = 50;
    logic [7:0]  rx_q[$];
    logic [31:0] fq[$];

    typedef struct {
        int         nfaces;
        bit         same;
        logic [7:0] exp_hdr;
        int         exp_len;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // UART model: accept each byte after a random 1..lat_max cycle delay.
    initial begin
        int lat;
        forever begin
            @(negedge clock);
            if (reset_n && send_uart_data) begin
                lat = int'($urandom_range(lat_max, 1));
                repeat (lat - 1) @(negedge clock);
                if (reset_n && send_uart_data) begin
                    rx_q.push_back(uart_data_tx);
                    uart_data_sent = 1'b1;
                    @(negedge clock);
                    uart_data_sent = 1'b0;
                end
            end
        end
    end

    logic       prev_send = 1'b0;
    logic [7:0] prev_tx = 8'h00;
    logic       sent_edge = 1'b0;

    always @(posedge clock) sent_edge <= uart_data_sent && send_uart_data;

    always @(negedge clock) begin
        if (reset_n && send_uart_data && prev_send) check("tx_stable", uart_data_tx, prev_tx);
        if (reset_n && sent_edge) check("send_drop", send_uart_data, 0);
        prev_send <= send_uart_data;
        prev_tx   <= uart_data_tx;
    end

    task automatic send_frame(input bit same);
        int n = fq.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            {x1, y1, x2, y2} = fq[i];
            face_vld   = 1'b1;
            frame_done = same && (i == n - 1);
            @(negedge clock);
            face_vld = 1'b0;
            if (frame_done) begin
                frame_done = 1'b0;
                check("hdr_latency", send_uart_data, 1);
                check("busy_set", busy, 1);
            end
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        if (!(same && n > 0)) begin
            @(negedge clock);
            frame_done = 1'b1;
            @(negedge clock);
            frame_done = 1'b0;
            check("hdr_latency", send_uart_data, 1);
            check("busy_set", busy, 1);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 20000) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_rx(input int n, input string tag);
        int k = 0;
        while (rx_q.size() < n && k < 5000) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_rx_wait"}, (rx_q.size() >= n), 1);
    endtask

    // Packet model: header {overflow, kept count}, then kept faces in arrival order.
    task automatic check_frame(input string tag);
        logic [7:0] exp[$];
        int         n = fq.size();
        int         keep = (n > MAX_FACES) ? MAX_FACES : n;
        logic       o = (n > MAX_FACES);
        exp.push_back({o, 7'(keep)});
        for (int i = 0; i < keep; i++) begin
            exp.push_back(fq[i][31:24]);
            exp.push_back(fq[i][23:16]);
            exp.push_back(fq[i][15:8]);
            exp.push_back(fq[i][7:0]);
        end
        check({tag, "_len"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp[i]);
        end
    endtask

    task automatic run_frame(input bit same, input string tag);
        rx_q.delete();
        send_frame(same);
        wait_idle(tag);
        check_frame(tag);
    endtask

    initial begin
        logic [7:0] exp2[9];
        logic [31:0] hdr;

        tbl[0] = '{nfaces: 0,  same: 1'b0, exp_hdr: 8'h00, exp_len: 1};
        tbl[1] = '{nfaces: 2,  same: 1'b0, exp_hdr: 8'h02, exp_len: 9};
        tbl[2] = '{nfaces: 30, same: 1'b0, exp_hdr: 8'h1E, exp_len: 121};
        tbl[3] = '{nfaces: 32, same: 1'b0, exp_hdr: 8'h9E, exp_len: 121};
        tbl[4] = '{nfaces: 1,  same: 1'b1, exp_hdr: 8'h01, exp_len: 5};

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_send", send_uart_data, 0);
        check("rst_tx", uart_data_tx, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_overrun", frame_overrun, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Table-driven frames
        for (int t = 0; t < 5; t++) begin
            fq.delete();
            for (int i = 0; i < tbl[t].nfaces; i++) fq.push_back($urandom);
            run_frame(tbl[t].same, $sformatf("tbl%0d", t));
            hdr = (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'hFFFF_FFFF;
            check($sformatf("tbl%0d_hdr", t), hdr, {24'h0, tbl[t].exp_hdr});
            check($sformatf("tbl%0d_nbytes", t), rx_q.size(), tbl[t].exp_len);
        end

        // Two known faces with literal byte stream
        exp2 = '{8'h02, 8'h0A, 8'h14, 8'h32, 8'h3C, 8'h01, 8'h02, 8'h03, 8'h04};
        fq = '{32'h0A14_323C, 32'h0102_0304};
        run_frame(1'b0, "two");
        for (int i = 0; i < 9; i++) begin
            hdr = (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF;
            check($sformatf("two_lit%0d", i), hdr, {24'h0, exp2[i]});
        end

        // Face and frame_done while transmitting are dropped and flagged
        fq.delete();
        for (int i = 0; i < 3; i++) fq.push_back($urandom);
        rx_q.delete();
        send_frame(1'b0);
        wait_rx(1, "ovr");
        {x1, y1, x2, y2} = 32'hDEAD_BEEF;
        face_vld   = 1'b1;
        frame_done = 1'b1;
        @(negedge clock);
        face_vld   = 1'b0;
        frame_done = 1'b0;
        check("ovr_flag", frame_overrun, 1);
        wait_idle("ovr");
        check_frame("ovr");
        fq = '{32'h1122_3344};
        run_frame(1'b0, "ovr_next");
        check("ovr_sticky", frame_overrun, 1);

        // Reset in the middle of the face bytes
        fq.delete();
        for (int i = 0; i < 3; i++) fq.push_back($urandom);
        rx_q.delete();
        send_frame(1'b0);
        wait_rx(3, "mid");
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_send", send_uart_data, 0);
        check("mid_rst_tx", uart_data_tx, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_overrun", frame_overrun, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        rx_q.delete();
        fq.delete();
        for (int i = 0; i < 2; i++) fq.push_back($urandom);
        run_frame(1'b0, "after_rst");

        // Random frames, shorter UART latency to keep the run short
        lat_max = 6;
        for (int f = 0; f < 20; f++) begin
            int n = int'($urandom_range(35, 0));
            fq.delete();
            for (int i = 0; i < n; i++) fq.push_back($urandom);
            run_frame((n > 0) && ($urandom_range(1, 0) == 1), $sformatf("rnd%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
